// File: rtl/cache_ctrl_wb.sv
// Direct-mapped, write-back, write-allocate cache controller with a
// request/ready processor port, a stalling memory port and saturating hit/miss counters.
module cache_ctrl_wb #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] inData,
    output logic [DATA_W-1:0] outData,
    output logic              ready,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                mode_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                ready_q;
    logic                hit_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [CNT_W-1:0]    hit_cnt_q;
    logic [CNT_W-1:0]    miss_cnt_q;
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [DATA_W-1:0]   data_q [LINES];

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic                line_hit;
    logic                line_dirty;
    logic                line_we;
    logic [DATA_W-1:0]   line_wdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign idx        = addr_q[INDEX_W-1:0];
    assign tag        = addr_q[ADDR_W-1:INDEX_W];
    assign line_hit   = valid_q[idx] && (tag_q[idx] == tag);
    assign line_dirty = valid_q[idx] && dirty_q[idx];

    // Single point where a line is (re)installed: write hit, clean write miss,
    // write after writeback, or refill completion.
    always_comb begin
        line_we    = 1'b0;
        line_wdata = wdata_q;
        case (state_q)
            LOOKUP:    line_we = mode_q && (line_hit || !line_dirty);
            WRITEBACK: line_we = mem_ack && mode_q;
            REFILL: begin
                line_we    = mem_ack;
                line_wdata = mem_rdata;
            end
            default:   line_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mode_q      <= 1'b0;
            wdata_q     <= '0;
            out_data_q  <= '0;
            ready_q     <= 1'b0;
            hit_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            ready_q <= 1'b0;
            hit_q   <= 1'b0;
            if (line_we) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= mode_q;
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        mode_q  <= mode;
                        wdata_q <= inData;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (line_hit) begin
                        if (!mode_q) out_data_q <= data_q[idx];
                        ready_q   <= 1'b1;
                        hit_q     <= 1'b1;
                        hit_cnt_q <= sat_inc(hit_cnt_q);
                        state_q   <= IDLE;
                    end else begin
                        miss_cnt_q <= sat_inc(miss_cnt_q);
                        if (line_dirty) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx};
                            mem_wdata_q <= data_q[idx];
                            state_q     <= WRITEBACK;
                        end else if (mode_q) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= addr_q;
                            state_q    <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        mem_we_q <= 1'b0;
                        if (mode_q) begin
                            mem_req_q <= 1'b0;
                            ready_q   <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            mem_addr_q <= addr_q;
                            state_q    <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        out_data_q <= mem_rdata;
                        ready_q    <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign outData    = out_data_q;
    assign ready      = ready_q;
    assign hit        = hit_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Directed bench for cache_ctrl_wb: cold miss, hits, write-allocate, dirty
// conflict with writeback then refill, reset mid-refill and counter saturation.
module tb_cache_ctrl_wb;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;
    localparam int INDEX_W = 8;
    localparam int CNT_W   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic              mode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] inData;
    logic [DATA_W-1:0] outData;
    logic              ready;
    logic              hit;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    int n_chk  = 0;
    int n_pass = 0;

    cache_ctrl_wb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .addr(addr),
        .inData(inData), .outData(outData), .ready(ready), .hit(hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for the sampling edge, then scramble the port so
    // the DUT must rely on its latched copy.
    task automatic issue(input logic m, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req    = 1'b1;
        mode   = m;
        addr   = a;
        inData = d;
        tick();
        req    = 1'b0;
        mode   = ~m;
        addr   = 24'hFFFFFF;
        inData = 32'hDEADBEEF;
    endtask

    // Wait (bounded) for a memory request, check it, hold it for `dly`
    // cycles, then acknowledge it for one cycle.
    task automatic mem_serve(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                             input int dly);
        for (int i = 0; i < 20 && !mem_req; i++) tick();
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
        if (we) chk({tag, "_mem_wdata"}, mem_wdata, wd);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk({tag, "_held"}, 32'(mem_req), 32'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20 && !ready; i++) tick();
        chk({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; mode = 1'b0; addr = '0; inData = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        #12;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_out", outData, 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Cold read miss, memory answers 3 cycles after the request.
        issue(1'b0, 24'h000000, 32'h0);
        tick();
        chk("cold_ready_lookup", 32'(ready), 32'd0);
        mem_serve("cold", 1'b0, 24'h000000, 32'h0, 32'h1234, 2);
        chk("cold_ready", 32'(ready), 32'd1);
        chk("cold_hit", 32'(hit), 32'd0);
        chk("cold_out", outData, 32'h1234);
        chk("cold_miss_cnt", 32'(miss_count), 32'd1);
        chk("cold_req_drop", 32'(mem_req), 32'd0);
        tick();
        chk("cold_ready_pulse", 32'(ready), 32'd0);

        // Re-read hits, ready in the cycle after E1.
        issue(1'b0, 24'h000000, 32'h0);
        tick();
        chk("reread_ready", 32'(ready), 32'd1);
        chk("reread_hit", 32'(hit), 32'd1);
        chk("reread_out", outData, 32'h1234);
        chk("reread_mem_req", 32'(mem_req), 32'd0);
        chk("reread_hit_cnt", 32'(hit_count), 32'd1);

        // Write miss on a clean line installs without touching memory.
        issue(1'b1, 24'hA7E5FB, 32'd46426);
        tick();
        chk("wmiss_mem_req", 32'(mem_req), 32'd0);
        chk("wmiss_ready", 32'(ready), 32'd1);
        chk("wmiss_hit", 32'(hit), 32'd0);
        chk("wmiss_out_kept", outData, 32'h1234);

        issue(1'b0, 24'hA7E5FB, 32'h0);
        tick();
        chk("wback_rd_ready", 32'(ready), 32'd1);
        chk("wback_rd_hit", 32'(hit), 32'd1);
        chk("wback_rd_out", outData, 32'd46426);

        // Conflict on index 0xFB with a dirty line: writeback then refill.
        issue(1'b0, 24'h0000FB, 32'h0);
        tick();
        mem_serve("conf_wb", 1'b1, 24'hA7E5FB, 32'd46426, 32'h0, 1);
        chk("conf_no_ready", 32'(ready), 32'd0);
        mem_serve("conf_rf", 1'b0, 24'h0000FB, 32'h0, 32'd4235, 0);
        chk("conf_ready", 32'(ready), 32'd1);
        chk("conf_hit", 32'(hit), 32'd0);
        chk("conf_out", outData, 32'd4235);
        chk("conf_miss_cnt", 32'(miss_count), 32'd3);
        chk("conf_hit_cnt", 32'(hit_count), 32'd2);

        // Reset while the refill waits for ack.
        issue(1'b0, 24'h000100, 32'h0);
        tick();
        chk("mid_mem_req", 32'(mem_req), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("mid_rst_ready2", 32'(ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(ready), 32'd0);
        chk("post_rst_miss_cnt", 32'(miss_count), 32'd0);

        issue(1'b0, 24'h000000, 32'h0);
        tick();
        chk("post_rst_ready_lookup", 32'(ready), 32'd0);
        mem_serve("post_rst", 1'b0, 24'h000000, 32'h0, 32'h55, 0);
        wait_ready("post_rst");
        chk("post_rst_hit", 32'(hit), 32'd0);
        chk("post_rst_out", outData, 32'h55);
        chk("post_rst_miss1", 32'(miss_count), 32'd1);

        // 20 read hits saturate a 4-bit hit counter at 15.
        for (int i = 0; i < 20; i++) begin
            issue(1'b0, 24'h000000, 32'h0);
            tick();
            if (i == 9) chk("sat_hit_cnt10", 32'(hit_count), 32'd10);
            if (i == 19) chk("sat_last_hit", 32'(hit), 32'd1);
        end
        chk("sat_hit_cnt", 32'(hit_count), 32'd15);
        tick();
        chk("sat_hit_stable", 32'(hit_count), 32'd15);
        chk("sat_miss_cnt", 32'(miss_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_ctrl_wb.md
# cache_ctrl_wb

Parametrised direct-mapped, write-back, write-allocate cache controller. It sits between the processor-side request port (address, data, read/write mode) and the backing RAM model, and replaces the fixed-size, always-ready cache model. It adds a request/ready handshake, dirty-line writeback, a stalling memory handshake, asynchronous reset, and saturating hit/miss counters.

## Interface
- `ADDR_W`, 24, word-address width.
- `DATA_W`, 32, word width; one word per line.
- `INDEX_W`, 8, index bits; 2**INDEX_W lines; tag width = ADDR_W-INDEX_W.
- `CNT_W`, 16, hit/miss counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: processor request valid; sampled only in IDLE.
- `mode` in 1: 0 = read, 1 = write.
- `addr` in ADDR_W: word address; index = addr[INDEX_W-1:0], tag = upper bits.
- `inData` in DATA_W: write data.
- `outData` out DATA_W: read data; holds its value until the next read completes.
- `ready` out 1: one-cycle completion pulse.
- `hit` out 1: valid while `ready`=1; 1 = hit, 0 = miss.
- `mem_req` out 1: memory request; held until acked.
- `mem_we` out 1: 1 = writeback, 0 = refill read.
- `mem_addr` out ADDR_W: memory word address.
- `mem_wdata` out DATA_W: writeback data.
- `mem_rdata` in DATA_W: refill data; valid when `mem_ack`=1.
- `mem_ack` in 1: one-cycle acknowledge.
- `hit_count` out CNT_W: saturating hit counter.
- `miss_count` out CNT_W: saturating miss counter.

## Operation
- Per line storage: valid, dirty, tag, data. Reset clears every valid and dirty bit; data and tag arrays need not be reset.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL.
- IDLE: with `req`=1, latch addr/mode/inData and go to LOOKUP. The latched values are used for the whole transaction; later port changes are ignored.
- LOOKUP, hit (valid and tag match):
  - Read: `outData` <= line data.
  - Write: line data <= inData, dirty <= 1.
  - In both cases: `ready`=1, `hit`=1, hit_count+1, go to IDLE.
- LOOKUP, miss: miss_count+1.
  - Line valid and dirty: go to WRITEBACK.
  - Otherwise: write -> install and finish; read -> go to REFILL.
- WRITEBACK: `mem_req`=1, `mem_we`=1, `mem_addr`={old tag, index}, `mem_wdata`=line data. On `mem_ack`:
  - Write: install the line and finish.
  - Read: go to REFILL.
- REFILL: `mem_req`=1, `mem_we`=0, `mem_addr`=latched addr. On `mem_ack`: line <= {valid=1, dirty=0, tag, mem_rdata}, `outData` <= mem_rdata, finish.
- Write miss install: line <= {valid=1, dirty=1, tag, inData}, no memory read.
- Finish: `ready`=1, `hit`=0, go to IDLE.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset takes effect asynchronously: `mem_req` and `ready` drop without waiting for a clock edge.
- All outputs are registered.
- Hit latency: `req` is sampled at edge E0, LOOKUP occupies E0..E1, and `ready` is high for the single cycle after E1.
- `ready` is deasserted at the next edge. A new `req` can be accepted at that same edge (back-to-back issue).
- Memory handshake:
  - `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are set at the edge entering WRITEBACK or REFILL.
  - They are held stable until the edge that samples `mem_ack`=1, and drop at that edge unless REFILL follows immediately.
  - `mem_ack` while `mem_req`=0 is ignored.
- WRITEBACK -> REFILL transition: `mem_req` stays high, and `mem_we`/`mem_addr` switch at the same edge.
- Miss latency: LOOKUP, plus WRITEBACK and/or REFILL each lasting until ack. `ready` is high in the cycle after the final ack edge.
- `req` asserted outside IDLE is ignored (not queued).
- Reset during WRITEBACK/REFILL: the transaction is abandoned, no line is modified, and no `ready` pulse is produced.

## Test plan
- Cold read: after reset, read addr 0x000000; memory acks 3 cycles after `mem_req` with 0x1234.
  - Expect `mem_req`=1, `mem_we`=0, `mem_addr`=0.
  - Then `ready`=1, `hit`=0, `outData`=0x1234, miss_count=1.
- Re-read 0x000000: `ready` in the 2nd cycle after the sampling edge, `hit`=1, `outData`=0x1234, no `mem_req`, hit_count=1.
- Write miss: write 46426 to 0xA7E5FB (index 0xFB) on a clean line.
  - Expect no `mem_req`; `ready`=1, `hit`=0.
  - Read back 0xA7E5FB: expect `hit`=1, `outData`=46426.
- Conflict: read 0x0000FB (same index, different tag) with the memory model returning 4235.
  - Expect WRITEBACK first: `mem_we`=1, `mem_addr`=0xA7E5FB, `mem_wdata`=46426.
  - Then REFILL: `mem_addr`=0x0000FB.
  - Then `outData`=4235, `hit`=0.
- Reset mid-refill: assert `rst_n`=0 while REFILL waits for ack.
  - `mem_req` falls immediately and `ready` stays 0.
  - After release, reading 0x000000 misses again.
- Counter saturation: with CNT_W=4, issue 20 read hits; expect hit_count=15 and stable.
